// File: rtl/mul_pkg.sv
// Shared definitions for the RV32M multiply requester: funct3 codes, FSM encoding
// and the operand magnitude helper.
package mul_pkg;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_FIX   = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // Two's-complement magnitude; 0x80000000 maps onto itself as an unsigned value.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        mag32 = (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Conditional 64-bit negate of the unsigned product, then selection of the
// 32-bit half returned to writeback.
module mul_sign_fix
    import mul_pkg::*;
(
    input  logic [63:0] res_i,
    input  logic        neg_i,
    input  logic        hi_i,
    output logic [31:0] data_o
);

    logic [63:0] prod;

    always_comb begin
        prod   = neg_i ? (~res_i + 64'd1) : res_i;
        data_o = hi_i ? prod[63:32] : prod[31:0];
    end

endmodule

// File: rtl/mul_req_ctrl.sv
// Requester side of the iterative multiplier handshake: takes RV32M multiplies from
// execute, issues one unsigned request, sign-corrects the product and responds.
module mul_req_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_rs1,
    input  logic [XLEN-1:0]   req_rs2,
    input  logic [4:0]        req_rd,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [XLEN-1:0]   rsp_data,
    output logic [4:0]        rsp_rd,
    output logic [XLEN-1:0]   mul_op1,
    output logic [XLEN-1:0]   mul_op2,
    output logic              mul_vld,
    input  logic [2*XLEN-1:0] mul_res,
    input  logic              mul_rdy
);

    state_e            state_q;
    logic              req_rdy_q, rsp_vld_q, mul_vld_q;
    logic              neg_q, hi_q;
    logic [XLEN-1:0]   op1_q, op2_q, rsp_data_q;
    logic [4:0]        rsp_rd_q;
    logic [2*XLEN-1:0] res_q;

    logic [2:0]        f3_d;
    logic              sgn_a_d, sgn_b_d, neg_d, hi_d, bypass_d;
    logic [XLEN-1:0]   mag_a_d, mag_b_d, fix_data;
    logic              unused_f3_bit2;

    // funct3 bit 2 selects divide ops elsewhere; only the low two bits matter here.
    assign unused_f3_bit2 = req_funct3[2];

    always_comb begin
        f3_d     = {1'b0, req_funct3[1:0]};
        sgn_a_d  = (f3_d == F_MULH) || (f3_d == F_MULHSU);
        sgn_b_d  = (f3_d == F_MULH);
        mag_a_d  = mag32(req_rs1, sgn_a_d);
        mag_b_d  = mag32(req_rs2, sgn_b_d);
        neg_d    = (sgn_a_d & req_rs1[XLEN-1]) ^ (sgn_b_d & req_rs2[XLEN-1]);
        hi_d     = (f3_d != F_MUL);
        bypass_d = ZERO_BYPASS && ((mag_a_d == '0) || (mag_b_d == '0));
    end

    mul_sign_fix u_sign_fix (
        .res_i  (res_q),
        .neg_i  (neg_q),
        .hi_i   (hi_q),
        .data_o (fix_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_rdy_q  <= 1'b1;
            rsp_vld_q  <= 1'b0;
            mul_vld_q  <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            rsp_data_q <= '0;
            rsp_rd_q   <= '0;
            res_q      <= '0;
            neg_q      <= 1'b0;
            hi_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_vld) begin
                        op1_q     <= mag_a_d;
                        op2_q     <= mag_b_d;
                        neg_q     <= neg_d;
                        hi_q      <= hi_d;
                        rsp_rd_q  <= req_rd;
                        req_rdy_q <= 1'b0;
                        if (bypass_d) begin
                            rsp_data_q <= '0;
                            rsp_vld_q  <= 1'b1;
                            state_q    <= S_RESP;
                        end else begin
                            mul_vld_q <= 1'b1;
                            state_q   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (mul_rdy) begin
                        res_q     <= mul_res;
                        mul_vld_q <= 1'b0;
                        state_q   <= S_FIX;
                    end
                end
                S_FIX: begin
                    rsp_data_q <= fix_data;
                    rsp_vld_q  <= 1'b1;
                    state_q    <= S_RESP;
                end
                S_RESP: begin
                    // Handshake frees the block; a new accept can only land next cycle.
                    if (rsp_rdy) begin
                        rsp_vld_q <= 1'b0;
                        req_rdy_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    req_rdy_q <= 1'b1;
                    rsp_vld_q <= 1'b0;
                    mul_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_rdy  = req_rdy_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;
    assign rsp_rd   = rsp_rd_q;
    assign mul_op1  = op1_q;
    assign mul_op2  = op2_q;
    assign mul_vld  = mul_vld_q;

endmodule

// File: tb/tb_mul_req_ctrl.sv
// Directed bench for mul_req_ctrl; the bench plays the multiplier with
// hand-computed products and checks every response.
module tb_mul_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld;
    logic        req_rdy;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_rd;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [31:0] mul_op1, mul_op2;
    logic        mul_vld;
    logic [63:0] mul_res;
    logic        mul_rdy;

    int tests = 0;
    int fails = 0;
    int rises = 0;
    int low_run = 0;
    int min_gap = 1000;
    logic vld_prev = 1'b0;

    always #5 clk = ~clk;

    mul_req_ctrl #(.XLEN(32), .ZERO_BYPASS(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_funct3 (req_funct3),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_rd     (req_rd),
        .rsp_vld    (rsp_vld),
        .rsp_rdy    (rsp_rdy),
        .rsp_data   (rsp_data),
        .rsp_rd     (rsp_rd),
        .mul_op1    (mul_op1),
        .mul_op2    (mul_op2),
        .mul_vld    (mul_vld),
        .mul_res    (mul_res),
        .mul_rdy    (mul_rdy)
    );

    // Multiplier-side monitor: counts mul_vld rises and the shortest low gap between them.
    always @(posedge clk) begin
        if (mul_vld && !vld_prev) begin
            rises <= rises + 1;
            if (rises > 0 && low_run < min_gap) min_gap <= low_run;
            low_run <= 0;
        end else if (!mul_vld) begin
            low_run <= low_run + 1;
        end
        vld_prev <= mul_vld;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] e1, input logic [31:0] e2,
                          input logic [63:0] res, input logic [31:0] edata, input int hold);
        int r0;
        chk({tag, ".idle_rdy"}, req_rdy, 1);
        r0 = rises;
        req_vld = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = rd;
        step();
        req_vld = 1'b0; req_rs1 = 32'hDEAD_BEEF; req_rs2 = 32'hCAFE_F00D; req_rd = 5'd31;
        chk({tag, ".mul_vld_t1"}, mul_vld, 1);
        chk({tag, ".op1"}, mul_op1, e1);
        chk({tag, ".op2"}, mul_op2, e2);
        chk({tag, ".busy_rdy"}, req_rdy, 0);
        step();
        chk({tag, ".mul_vld_held"}, mul_vld, 1);
        mul_rdy = 1'b1; mul_res = res;
        step();
        mul_rdy = 1'b0; mul_res = 64'h5A5A_5A5A_A5A5_A5A5;
        chk({tag, ".fix_vld_low"}, mul_vld, 0);
        chk({tag, ".fix_rsp_low"}, rsp_vld, 0);
        step();
        chk({tag, ".rsp_vld"}, rsp_vld, 1);
        chk({tag, ".rsp_data"}, rsp_data, edata);
        chk({tag, ".rsp_rd"}, rsp_rd, rd);
        chk({tag, ".resp_vld_low"}, mul_vld, 0);
        for (int i = 0; i < hold; i++) begin
            req_vld = 1'b1;
            step();
            chk({tag, ".bp_vld"}, rsp_vld, 1);
            chk({tag, ".bp_data"}, rsp_data, edata);
            chk({tag, ".bp_rdy"}, req_rdy, 0);
        end
        req_vld = 1'b0;
        rsp_rdy = 1'b1;
        step();
        rsp_rdy = 1'b0;
        chk({tag, ".done_vld"}, rsp_vld, 0);
        chk({tag, ".done_rdy"}, req_rdy, 1);
        chk({tag, ".one_rise"}, rises - r0, 1);
    endtask

    initial begin
        int r0;
        rst = 1'b1; req_vld = 1'b0; req_funct3 = 3'b000; req_rs1 = '0; req_rs2 = '0;
        req_rd = '0; rsp_rdy = 1'b0; mul_res = '0; mul_rdy = 1'b0;
        step();
        step();
        chk("rst.req_rdy", req_rdy, 1);
        chk("rst.rsp_vld", rsp_vld, 0);
        chk("rst.mul_vld", mul_vld, 0);
        chk("rst.op1", mul_op1, 0);
        chk("rst.op2", mul_op2, 0);
        chk("rst.rsp_data", rsp_data, 0);
        chk("rst.rsp_rd", rsp_rd, 0);
        rst = 1'b0;
        step();

        // Back-to-back sequence: each op is accepted the cycle after the previous response.
        run_op("mul7x6", 3'b000, 32'd7, 32'd6, 5'd5, 32'd7, 32'd6,
               64'h2A, 32'h0000_002A, 0);
        run_op("mulh_m1m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'd1, 32'd1,
               64'h1, 32'h0000_0000, 0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFE, 32'h0000_0003, 5'd2, 32'd2, 32'd3,
               64'h6, 32'hFFFF_FFFF, 0);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFE, 0);
        run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4,
               32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32'h4000_0000, 0);
        run_op("mul_bit2_bp", 3'b100, 32'hFFFF_FFFF, 32'h0000_0002, 5'd9,
               32'hFFFF_FFFF, 32'h0000_0002, 64'h1_FFFF_FFFE, 32'hFFFF_FFFE, 10);
        run_op("mulh_neg", 3'b001, 32'hFFFF_FFFD, 32'h0000_0005, 5'd12, 32'd3, 32'd5,
               64'hF, 32'hFFFF_FFFF, 0);
        chk("gap_min2", (min_gap >= 2), 1);

        // Zero bypass: response next cycle, multiplier never requested.
        r0 = rises;
        req_vld = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'h1234; req_rs2 = 32'h0; req_rd = 5'd7;
        step();
        req_vld = 1'b0;
        chk("byp.rsp_vld", rsp_vld, 1);
        chk("byp.rsp_data", rsp_data, 0);
        chk("byp.rsp_rd", rsp_rd, 7);
        chk("byp.mul_vld", mul_vld, 0);
        rsp_rdy = 1'b1;
        step();
        rsp_rdy = 1'b0;
        step();
        chk("byp.no_rise", rises - r0, 0);
        chk("byp.idle", req_rdy, 1);

        // Stray mul_rdy in IDLE must not start anything.
        mul_rdy = 1'b1; mul_res = 64'h1111_2222_3333_4444;
        step();
        mul_rdy = 1'b0;
        step();
        chk("stray.rsp_vld", rsp_vld, 0);
        chk("stray.req_rdy", req_rdy, 1);
        chk("stray.mul_vld", mul_vld, 0);

        // Reset while waiting in ISSUE, then a stale product pulse.
        req_vld = 1'b1; req_funct3 = 3'b011; req_rs1 = 32'd9; req_rs2 = 32'd9; req_rd = 5'd20;
        step();
        req_vld = 1'b0;
        chk("rstmid.issue", mul_vld, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid.mul_vld", mul_vld, 0);
        chk("rstmid.rsp_vld", rsp_vld, 0);
        chk("rstmid.req_rdy", req_rdy, 1);
        mul_rdy = 1'b1; mul_res = 64'd81;
        step();
        mul_rdy = 1'b0;
        step();
        step();
        chk("stale.rsp_vld", rsp_vld, 0);
        chk("stale.req_rdy", req_rdy, 1);
        chk("stale.mul_vld", mul_vld, 0);

        run_op("after_rst", 3'b000, 32'd100, 32'd3, 5'd30, 32'd100, 32'd3,
               64'd300, 32'd300, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
